// File: rtl/cla_pkg.sv
// Shared constants and types for the carry-lookahead adder pipeline.
package cla_pkg;

   localparam int unsigned GROUP = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned NGRP  = WIDTH / GROUP;

   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic             cin;
      logic [NGRP-1:0]  gp;
      logic [NGRP-1:0]  gg;
   } pg_beat_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/cla_group_pg.sv
// 4-bit group propagate/generate; reused by the second-level lookahead.
module cla_group_pg
   import cla_pkg::*;
(
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   output logic             gp_c,
   output logic             gg_c
);

   assign gp_c = p[3] & p[2] & p[1] & p[0];
   assign gg_c = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pg_stage.sv
// Registered p/g front-end for the 8-bit CLA with a 2-entry skid buffer.
module cla_pg_stage
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p_out,
   output logic [WIDTH-1:0] g_out,
   output logic             cin_out,
   output logic [NGRP-1:0]  gp_out,
   output logic [NGRP-1:0]  gg_out
);

   logic [WIDTH-1:0] p_c;
   logic [WIDTH-1:0] g_c;
   logic [NGRP-1:0]  gp_c;
   logic [NGRP-1:0]  gg_c;
   pg_beat_t         beat_c;

   skid_state_t state;
   skid_state_t next_state;
   pg_beat_t    main_q;
   pg_beat_t    skid_q;
   logic        in_xfer_c;
   logic        out_xfer_c;
   logic        load_main_c;
   logic        main_from_skid_c;
   logic        load_skid_c;

   assign p_c = a ^ b;
   assign g_c = a & b;

   for (genvar k = 0; k < int'(NGRP); k++) begin : g_grp
      cla_group_pg u_grp (
         .p    (p_c[k*GROUP +: GROUP]),
         .g    (g_c[k*GROUP +: GROUP]),
         .gp_c (gp_c[k]),
         .gg_c (gg_c[k])
      );
   end

   assign beat_c = '{p: p_c, g: g_c, cin: cin, gp: gp_c, gg: gg_c};

   assign in_xfer_c  = in_valid & in_ready;
   assign out_xfer_c = out_valid & out_ready;

   // State register; the handshake flags are precomputed from next_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= next_state;
         out_valid <= (next_state != EMPTY);
         in_ready  <= (next_state != FULL);
      end
   end

   always_comb begin
      next_state       = state;
      load_main_c      = 1'b0;
      main_from_skid_c = 1'b0;
      load_skid_c      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer_c) begin
               next_state  = ONE;
               load_main_c = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer_c && out_xfer_c) begin
               load_main_c = 1'b1;
            end else if (in_xfer_c) begin
               next_state  = FULL;
               load_skid_c = 1'b1;
            end else if (out_xfer_c) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer_c) begin
               next_state       = ONE;
               main_from_skid_c = 1'b1;
            end
         end
         default: next_state = EMPTY;
      endcase
   end

   // Payload storage: main drives the outputs, skid absorbs one stalled beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_c) begin
            main_q <= beat_c;
         end else if (main_from_skid_c) begin
            main_q <= skid_q;
         end
         if (load_skid_c) begin
            skid_q <= beat_c;
         end
      end
   end

   assign p_out   = main_q.p;
   assign g_out   = main_q.g;
   assign cin_out = main_q.cin;
   assign gp_out  = main_q.gp;
   assign gg_out  = main_q.gg;

endmodule

// File: tb/tb_cla_pg_stage.sv
// Scoreboard bench for cla_pg_stage: directed cases plus random handshake traffic.
module tb_cla_pg_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] p_out;
   logic [7:0] g_out;
   logic       cin_out;
   logic [1:0] gp_out;
   logic [1:0] gg_out;

   int n_chk = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;
   logic [20:0] sb_q[$];

   always #5 clk = ~clk;

   cla_pg_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p_out     (p_out),
      .g_out     (g_out),
      .cin_out   (cin_out),
      .gp_out    (gp_out),
      .gg_out    (gg_out)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: group generate is the ripple carry-out of the group with cin=0.
   function automatic logic [20:0] exp_beat(input logic [7:0] ea, input logic [7:0] eb,
                                            input logic ec);
      logic [7:0] p;
      logic [7:0] g;
      logic [1:0] gp;
      logic [1:0] gg;
      logic       c;
      p = ea ^ eb;
      g = ea & eb;
      for (int k = 0; k < 2; k++) begin
         c     = 1'b0;
         gp[k] = 1'b1;
         for (int i = 0; i < 4; i++) begin
            c     = g[4*k+i] | (p[4*k+i] & c);
            gp[k] = gp[k] & p[4*k+i];
         end
         gg[k] = c;
      end
      return {p, g, ec, gp, gg};
   endfunction

   function automatic logic [20:0] dut_beat();
      return {p_out, g_out, cin_out, gp_out, gg_out};
   endfunction

   // Inputs change just after posedge, so at negedge they show the coming edge's transfers.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
         chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
         if (out_valid && sb_q.size() > 0) begin
            chk("beat", 64'(dut_beat()), 64'(sb_q[0]));
            if (out_ready) void'(sb_q.pop_front());
         end
         if (in_valid && in_ready) sb_q.push_back(exp_beat(a, b, cin));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                        input logic dc);
      in_valid = v;
      a        = da;
      b        = db;
      cin      = dc;
   endtask

   task automatic drain(input int budget);
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      n = 0;
      while (sb_q.size() > 0 && n < budget) begin
         cyc();
         n++;
      end
      chk("drain_timeout", 64'(sb_q.size()), 64'(0));
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_payload", 64'(dut_beat()), 64'(0));
      cyc();
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Basic beat
      drive(1'b1, 8'h0F, 8'h01, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk("basic_valid", 64'(out_valid), 64'(1));
      chk("basic_payload", 64'(dut_beat()), 64'({8'h0E, 8'h01, 1'b0, 2'b00, 2'b01}));
      cyc();

      // Full propagate and top-bit generate
      drive(1'b1, 8'hFF, 8'h00, 1'b1);
      cyc();
      drive(1'b1, 8'h80, 8'h80, 1'b0);
      @(negedge clk);
      chk("fullprop_payload", 64'(dut_beat()), 64'({8'hFF, 8'h00, 1'b1, 2'b11, 2'b00}));
      cyc();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk("msb_payload", 64'(dut_beat()), 64'({8'h00, 8'h80, 1'b0, 2'b00, 2'b10}));
      drain(10);

      // Backpressure: A, B accepted, C held while stalled
      out_ready = 1'b0;
      drive(1'b1, 8'h01, 8'h00, 1'b0);
      cyc();
      drive(1'b1, 8'h02, 8'h00, 1'b0);
      cyc();
      drive(1'b1, 8'h03, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_hold_a", 64'(p_out), 64'(8'h01));
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      @(negedge clk);
      chk("bp_ready_back", 64'(in_ready), 64'(1));
      chk("bp_second_b", 64'(p_out), 64'(8'h02));
      cyc();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk("bp_third_c", 64'(p_out), 64'(8'h03));
      drain(10);

      // Streaming: 16 back-to-back beats
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'(i), ~8'(i), 1'b0);
         cyc();
         chk("stream_valid", 64'(out_valid), 64'(1));
         chk("stream_p", 64'(p_out), 64'(8'hFF));
      end
      drain(10);

      // Reset mid-operation while FULL
      out_ready = 1'b0;
      drive(1'b1, 8'h11, 8'h22, 1'b1);
      cyc();
      drive(1'b1, 8'h33, 8'h44, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
      chk("mid_rst_payload", 64'(dut_beat()), 64'(0));
      sb_q.delete();
      cyc();
      rst_n     = 1'b1;
      mon_en    = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 8'h55, 8'hAA, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      chk("post_rst_p", 64'(p_out), 64'(8'hFF));
      drain(10);

      // Random traffic; X data offered whenever the block cannot accept
      for (int i = 0; i < 10000; i++) begin
         out_ready = 1'($urandom_range(0, 3) != 0);
         if (!in_ready) begin
            drive(1'($urandom_range(0, 1)), 'x, 'x, 'x);
         end else begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom));
         end
         cyc();
      end
      drain(20);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
